// File: rtl/datapath_towerplacer.sv
// Datapath for the tower-placement FSM: grid cursor, free-cell search, and the
// pixel streams (cursor outline, erase outline, tower fill) for a 160x120 VGA
// adapter. Optional feature macro: TOWER_PLACER_OCCUPANCY_EN keeps a per-cell
// occupancy bitmap so placed towers are skipped by seek and move.
module datapath_towerplacer #(
  parameter int         GRID_COLS     = 8,
  parameter int         GRID_ROWS     = 6,
  parameter int         CELL_SIZE     = 16,
  parameter int         X_OFFSET      = 0,
  parameter int         Y_OFFSET      = 0,
  parameter logic [2:0] SQUARE_COLOUR = 3'b110,
  parameter logic [2:0] BG_COLOUR     = 3'b010,
  parameter logic [2:0] TOWER_COLOUR  = 3'b001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       top_left,
  input  logic       draw_square,
  input  logic       erase_square_right,
  input  logic       erase_square_down,
  input  logic       erase_square_tower,
  input  logic       move_right,
  input  logic       move_down,
  input  logic       draw_tower,
  input  logic       cell_blocked,
  output logic [5:0] cell_addr,
  output logic       enable_draw,
  output logic       valid,
  output logic       square_done,
  output logic       erase_square_done,
  output logic       tower_done,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic [5:0] tower_count
);

  localparam int COL_W = (GRID_COLS > 1) ? $clog2(GRID_COLS) : 1;
  localparam int ROW_W = (GRID_ROWS > 1) ? $clog2(GRID_ROWS) : 1;
  localparam int CNT_W = $clog2(CELL_SIZE);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(GRID_COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GRID_ROWS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CELL_SIZE - 1);

  // Operation selected by the (nominally one-hot) FSM strobes.
  typedef enum logic [2:0] {
    OP_IDLE, OP_SEEK, OP_TOWER, OP_ERASE, OP_SQUARE, OP_RIGHT, OP_DOWN
  } op_e;

  // Phase of the shared pixel counter within one draw.
  typedef enum logic [1:0] {PIX_RUN, PIX_PULSE, PIX_HOLD} pix_state_e;

  op_e              op;
  logic             is_move;
  logic             draw_op;

  logic [COL_W-1:0] cur_col, cand_col, start_col;
  logic [ROW_W-1:0] cur_row, cand_row, start_row;
  logic             seeking;
  logic             move_active;
  logic             cand_free;
  logic             cand_is_last;
  logic             full_wrap;

  pix_state_e       pix_state, pix_next;
  logic [CNT_W-1:0] pix_i, pix_j;
  logic             pix_last;
  logic             pix_edge;
  logic             pix_emit;
  logic             pix_pulse;

  // Priority decode of the strobes; illegal overlaps resolve deterministically.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can leave it unassigned and infer a latch.
    op = OP_IDLE;
    if (top_left)                                                        op = OP_SEEK;
    else if (draw_tower)                                                 op = OP_TOWER;
    else if (erase_square_right || erase_square_down || erase_square_tower) op = OP_ERASE;
    else if (draw_square)                                                op = OP_SQUARE;
    else if (move_right)                                                 op = OP_RIGHT;
    else if (move_down)                                                  op = OP_DOWN;
  end

  assign is_move = (op == OP_RIGHT) || (op == OP_DOWN);
  assign draw_op = (op == OP_TOWER) || (op == OP_ERASE) || (op == OP_SQUARE);

  // Candidate cell: scan index during seek, neighbour during moves, cursor otherwise.
  always_comb begin
    cand_col = cur_col;
    cand_row = cur_row;
    case (op)
      OP_SEEK: begin
        if (!enable_draw) begin
          if (!seeking) begin
            cand_col = '0;
            cand_row = '0;
          end else if (cur_col == COL_LAST) begin
            cand_col = '0;
            cand_row = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
          end else begin
            cand_col = cur_col + 1'b1;
          end
        end
      end
      OP_RIGHT: cand_col = (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
      OP_DOWN:  cand_row = (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;
      default: ;
    endcase
  end

  assign cell_addr    = 6'(int'(cand_row) * GRID_COLS + int'(cand_col));
  assign cand_is_last = (cand_col == COL_LAST) && (cand_row == ROW_LAST);
  assign full_wrap    = move_active && (cand_col == start_col) && (cand_row == start_row);
  assign valid        = is_move && (cand_free || full_wrap);

`ifdef TOWER_PLACER_OCCUPANCY_EN
  logic [GRID_COLS*GRID_ROWS-1:0] occupied;
  logic [5:0]                     cur_addr;

  assign cur_addr  = 6'(int'(cur_row) * GRID_COLS + int'(cur_col));
  assign cand_free = !cell_blocked && !occupied[cell_addr];

  // Occupancy bitmap: a cell is marked on the clk its tower fill completes.
  always_ff @(posedge clk) begin
    // NOTE: this bitmap is plain flops (not a RAM), so it can and must be cleared by reset.
    if (reset)                           occupied           <= '0;
    else if (pix_pulse && op == OP_TOWER) occupied[cur_addr] <= 1'b1;
  end
`else
  assign cand_free = !cell_blocked;
`endif

  // Cursor, seek progress and move bookkeeping.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      cur_col     <= '0;
      cur_row     <= '0;
      seeking     <= 1'b0;
      enable_draw <= 1'b0;
      move_active <= 1'b0;
      start_col   <= '0;
      start_row   <= '0;
    end else begin
      if (op == OP_SEEK) begin
        if (!enable_draw) begin
          seeking <= 1'b1;
          if (cand_free) begin
            cur_col     <= cand_col;
            cur_row     <= cand_row;
            enable_draw <= 1'b1;
          end else if (cand_is_last) begin
            cur_col     <= '0;
            cur_row     <= '0;
            enable_draw <= 1'b1;
          end else begin
            cur_col <= cand_col;
            cur_row <= cand_row;
          end
        end
      end else begin
        seeking     <= 1'b0;
        enable_draw <= 1'b0;
      end

      if (is_move) begin
        cur_col <= cand_col;
        cur_row <= cand_row;
        if (!move_active) begin
          start_col <= cur_col;
          start_row <= cur_row;
        end
      end
      move_active <= is_move;
    end
  end

  assign pix_last = (pix_i == CNT_LAST) && (pix_j == CNT_LAST);
  assign pix_edge = (pix_i == '0) || (pix_j == '0) || (pix_i == CNT_LAST) || (pix_j == CNT_LAST);

  // Pixel phase register.
  always_ff @(posedge clk) begin
    if (reset) pix_state <= PIX_RUN;
    else       pix_state <= pix_next;
  end

  // Pixel phase next-state: emit pixels, then one done pulse, then hold.
  always_comb begin
    pix_next  = pix_state;
    pix_emit  = 1'b0;
    pix_pulse = 1'b0;
    if (!draw_op) begin
      pix_next = PIX_RUN;
    end else begin
      case (pix_state)
        PIX_RUN: begin
          pix_emit = 1'b1;
          if (pix_last) pix_next = PIX_PULSE;
        end
        PIX_PULSE: begin
          pix_pulse = 1'b1;
          pix_next  = PIX_HOLD;
        end
        default: ;
      endcase
    end
  end

  // Row-major pixel counter; cleared whenever no draw is in progress.
  always_ff @(posedge clk) begin
    if (reset || !draw_op) begin
      pix_i <= '0;
      pix_j <= '0;
    end else if (pix_emit && !pix_last) begin
      if (pix_i == CNT_LAST) begin
        pix_i <= '0;
        pix_j <= pix_j + 1'b1;
      end else begin
        pix_i <= pix_i + 1'b1;
      end
    end
  end

  // Registered pixel stream and done pulses, one clk behind the counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      x                 <= '0;
      y                 <= '0;
      colour            <= '0;
      plot              <= 1'b0;
      square_done       <= 1'b0;
      erase_square_done <= 1'b0;
      tower_done        <= 1'b0;
    end else begin
      plot              <= 1'b0;
      square_done       <= pix_pulse && (op == OP_SQUARE);
      erase_square_done <= pix_pulse && (op == OP_ERASE);
      tower_done        <= pix_pulse && (op == OP_TOWER);
      if (pix_emit) begin
        x <= 8'(X_OFFSET + int'(cur_col) * CELL_SIZE + int'(pix_i));
        y <= 7'(Y_OFFSET + int'(cur_row) * CELL_SIZE + int'(pix_j));
        case (op)
          OP_TOWER: begin
            plot   <= !pix_edge;
            colour <= TOWER_COLOUR;
          end
          OP_ERASE: begin
            plot   <= pix_edge;
            colour <= BG_COLOUR;
          end
          default: begin
            plot   <= pix_edge;
            colour <= SQUARE_COLOUR;
          end
        endcase
      end
    end
  end

  // Saturating count of committed towers.
  always_ff @(posedge clk) begin
    if (reset)                                                   tower_count <= '0;
    else if (pix_pulse && op == OP_TOWER && tower_count != '1)   tower_count <= tower_count + 1'b1;
  end

endmodule

// File: tb/tb_datapath_towerplacer.sv
// Self-checking bench for datapath_towerplacer: directed scenarios plus
// randomized operations against a cell/pixel-level reference model.
module tb_datapath_towerplacer;

  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int CS   = 16;
  localparam int NC   = COLS * ROWS;

  logic       clk = 1'b0;
  logic       reset;
  logic       top_left, draw_square, erase_square_right, erase_square_down, erase_square_tower;
  logic       move_right, move_down, draw_tower;
  logic       cell_blocked;
  logic [5:0] cell_addr;
  logic       enable_draw, valid, square_done, erase_square_done, tower_done;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic [5:0] tower_count;

  logic [63:0] rom_map = '1;
  bit   [63:0] occ     = '0;
  int          m_col, m_row, m_count;
  int          n_checks = 0;
  int          n_errors = 0;

  datapath_towerplacer dut (
    .clk(clk), .reset(reset), .top_left(top_left), .draw_square(draw_square),
    .erase_square_right(erase_square_right), .erase_square_down(erase_square_down),
    .erase_square_tower(erase_square_tower), .move_right(move_right), .move_down(move_down),
    .draw_tower(draw_tower), .cell_blocked(cell_blocked), .cell_addr(cell_addr),
    .enable_draw(enable_draw), .valid(valid), .square_done(square_done),
    .erase_square_done(erase_square_done), .tower_done(tower_done), .x(x), .y(y),
    .colour(colour), .plot(plot), .tower_count(tower_count)
  );

  always #5 clk = ~clk;

  // Map ROM: combinational lookup of the addressed cell.
  assign cell_blocked = rom_map[cell_addr];

  initial begin
    repeat (100000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_strobes();
    top_left = 0; draw_square = 0; erase_square_right = 0; erase_square_down = 0;
    erase_square_tower = 0; move_right = 0; move_down = 0; draw_tower = 0;
  endtask

  function automatic bit m_free(int idx);
`ifdef TOWER_PLACER_OCCUPANCY_EN
    return !rom_map[idx] && !occ[idx];
`else
    return !rom_map[idx];
`endif
  endfunction

  function automatic int step_right(int idx);
    return (idx / COLS) * COLS + ((idx % COLS) + 1) % COLS;
  endfunction

  function automatic int step_down(int idx);
    return (((idx / COLS) + 1) % ROWS) * COLS + (idx % COLS);
  endfunction

  function automatic logic [31:0] pack(int xe, int ye, int ce);
    return {14'd0, 8'(xe), 7'(ye), 3'(ce)};
  endfunction

  task automatic model_reset();
    m_col = 0; m_row = 0; m_count = 0; occ = '0;
  endtask

  task automatic set_rom_prefix(int n);
    for (int k = 0; k < NC; k++) rom_map[k] = (k < n);
  endtask

  task automatic do_reset();
    clear_strobes();
    reset = 1;
    tick(); tick();
    model_reset();
    check("rst_plot", plot, 0);
    check("rst_enable_draw", enable_draw, 0);
    check("rst_square_done", square_done, 0);
    check("rst_erase_done", erase_square_done, 0);
    check("rst_tower_done", tower_done, 0);
    check("rst_tower_count", tower_count, 0);
    check("rst_xyc", {14'd0, x, y, colour}, 0);
    reset = 0;
    tick();
    check("rst_cell_addr", cell_addr, 0);
    check("rst_valid", valid, 0);
    check("rst_plot_after", plot, 0);
  endtask

  task automatic do_seek();
    int exp_idx = 0;
    int exp_cyc = NC;
    int n = 0;
    for (int k = NC - 1; k >= 0; k--) if (m_free(k)) begin exp_idx = k; exp_cyc = k + 1; end
    top_left = 1;
    while (enable_draw !== 1'b1 && n < 100) begin
      #1;
      if (n < exp_cyc) check("seek_scan", cell_addr, n);
      tick();
      n++;
    end
    check("seek_cycles", n, exp_cyc);
    check("seek_addr", cell_addr, exp_idx);
    top_left = 0;
    tick();
    check("seek_release", enable_draw, 0);
    m_col = exp_idx % COLS;
    m_row = exp_idx / COLS;
  endtask

  task automatic do_move(input bit down);
    int start = m_row * COLS + m_col;
    int c;
    int k = 1;
    int n = 0;
    bit found = 0;
    c = down ? step_down(start) : step_right(start);
    while (!(m_free(c) || c == start)) begin
      c = down ? step_down(c) : step_right(c);
      k++;
    end
    move_right = !down;
    move_down  = down;
    while (!found && n < 60) begin
      #1;
      if (valid === 1'b1) found = 1;
      else begin tick(); n++; end
    end
    check(down ? "move_down_cycles" : "move_right_cycles", n + 1, k);
    check("move_addr", cell_addr, c);
    tick();
    move_right = 0;
    move_down  = 0;
    #1;
    check("move_cursor", cell_addr, c);
    m_col = c % COLS;
    m_row = c / COLS;
    tick();
  endtask

  // kind: 0 cursor outline, 1 erase outline, 2 tower fill
  task automatic do_draw(input int kind);
    logic [31:0] q[$];
    int exp_total, nplots = 0, pulses = 0, pulse_t = 0, wrong = 0;
    int ce;
    bit edge_px, want, done_sel, done_other;
    ce = (kind == 0) ? 6 : (kind == 1) ? 2 : 1;
    for (int j = 0; j < CS; j++)
      for (int i = 0; i < CS; i++) begin
        edge_px = (i == 0) || (j == 0) || (i == CS - 1) || (j == CS - 1);
        want    = (kind == 2) ? !edge_px : edge_px;
        if (want) q.push_back(pack(m_col * CS + i, m_row * CS + j, ce));
      end
    exp_total = q.size();
    case (kind)
      0: draw_square = 1;
      1: case ($urandom_range(0, 2))
           0:       erase_square_right = 1;
           1:       erase_square_down  = 1;
           default: erase_square_tower = 1;
         endcase
      default: draw_tower = 1;
    endcase
    for (int t = 1; t <= 260; t++) begin
      tick();
      if (plot === 1'b1) begin
        nplots++;
        if (q.size() != 0) check("pixel", {14'd0, x, y, colour}, q.pop_front());
      end
      done_sel   = (kind == 0) ? square_done : (kind == 1) ? erase_square_done : tower_done;
      done_other = (kind == 0) ? (erase_square_done | tower_done) :
                   (kind == 1) ? (square_done | tower_done) : (square_done | erase_square_done);
      if (done_sel) begin
        pulses++;
        pulse_t = t;
        check("done_plot", plot, 0);
      end
      if (done_other) wrong++;
    end
    check("plot_count", nplots, exp_total);
    check("done_pulses", pulses, 1);
    check("done_time", pulse_t, CS * CS + 1);
    check("wrong_done", wrong, 0);
    if (kind == 2) begin
      m_count = (m_count < 63) ? m_count + 1 : 63;
      occ[m_row * COLS + m_col] = 1;
      check("tower_count", tower_count, m_count);
    end
    clear_strobes();
    tick();
    check("plot_idle", plot, 0);
  endtask

  task automatic reset_mid_tower();
    int seen = 0;
    draw_tower = 1;
    repeat (101) tick();
    check("pix100_plot", plot, 1);
    check("pix100_xyc", {14'd0, x, y, colour}, pack(m_col * CS + 4, m_row * CS + 6, 1));
    reset = 1;
    tick();
    check("abort_plot", plot, 0);
    check("abort_done", tower_done, 0);
    reset = 0;
    draw_tower = 0;
    model_reset();
    repeat (5) begin
      tick();
      if (tower_done) seen++;
    end
    check("abort_no_done", seen, 0);
    check("abort_count", tower_count, 0);
  endtask

  initial begin
    clear_strobes();
    reset = 0;
    do_reset();
    reset_mid_tower();

    // Cells 0-2 blocked: seek lands on (3,0), then outline it.
    set_rom_prefix(3);
    do_seek();
    do_draw(0);

    // Cursor (7,2), column 0 blocked: move_right lands on (1,2).
    set_rom_prefix(23);
    do_seek();
    for (int k = 0; k < NC; k++) rom_map[k] = (k % COLS == 0);
    do_move(0);

    // Cursor (4,1), column 4 blocked except row 1: full wrap.
    set_rom_prefix(12);
    do_seek();
    for (int k = 0; k < NC; k++) rom_map[k] = (k % COLS == 4) && (k / COLS != 1);
    do_move(1);

    // Tower at (5,3), then move_right from (4,3).
    set_rom_prefix(29);
    do_seek();
    do_draw(2);
    set_rom_prefix(28);
    do_seek();
    set_rom_prefix(0);
    do_move(0);

    // Every cell blocked: seek gives up at index 0.
    set_rom_prefix(NC);
    do_seek();

    // Randomized operations over random maps.
    for (int r = 0; r < 25; r++) begin
      int density = $urandom_range(0, 90);
      for (int k = 0; k < NC; k++) rom_map[k] = ($urandom_range(0, 99) < density);
      case ($urandom_range(0, 5))
        0: do_seek();
        1: do_move(0);
        2: do_move(1);
        3: do_draw(0);
        4: do_draw(1);
        default: do_draw(2);
      endcase
    end

    // Fill tower_count to saturation and one beyond.
    set_rom_prefix(0);
    while (m_count < 63) do_draw(2);
    do_draw(2);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
